// File: rtl/delay_pkg.sv
// Shared types and default sizing for the DELAY instruction sequencer.
package delay_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DLY_W_DEF    = 16;
    localparam int PRESCALE_DEF = 100000;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that produces one tick every PRESCALE enabled clocks.
module tick_prescaler
    import delay_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int PS_W     = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + PS_W'(1);
        end
    end

endmodule

// File: rtl/delay_ctrl.sv
// DELAY instruction sequencer: stalls the PC for dly_val time units, then
// releases it for exactly one increment via a single-cycle count_done.
module delay_ctrl
    import delay_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEF,
    parameter int DLY_W    = DLY_W_DEF,
    parameter int PS_W     = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dly_req,
    input  logic [DLY_W-1:0] dly_val,
    input  logic             halt,
    input  logic             pause,
    output logic             delay,
    output logic             count_done,
    output logic             busy,
    output logic [DLY_W-1:0] remain
);

    state_t           state_q;
    state_t           state_d;
    logic [DLY_W-1:0] remain_d;
    logic             abort;
    logic             ps_clr;
    logic             ps_en;
    logic             tick;

    // Stall follows the decoder directly so the PC never slips a cycle.
    assign delay = dly_req && !halt;

    assign abort  = (state_q != IDLE) && (!dly_req || halt);
    assign ps_clr = (state_q != COUNT) || abort;
    assign ps_en  = (state_q == COUNT) && !abort && !pause;

    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (ps_clr),
        .en   (ps_en),
        .tick (tick)
    );

    // NOTE: every signal driven here gets a default first; a path that
    // skips an assignment would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        remain_d = remain;
        case (state_q)
            IDLE: begin
                if (dly_req && !halt) begin
                    if (dly_val == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = COUNT;
                        remain_d = dly_val;
                    end
                end
            end
            COUNT: begin
                if (abort) begin
                    state_d  = IDLE;
                    remain_d = '0;
                end else if (tick && (remain != '0)) begin
                    remain_d = remain - DLY_W'(1);
                    if (remain == DLY_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d  = IDLE;
                remain_d = '0;
            end
            default: begin
                state_d  = IDLE;
                remain_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            remain     <= '0;
            count_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            remain     <= remain_d;
            count_done <= (state_d == DONE);
            busy       <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_delay_ctrl.sv
// Self-checking bench for delay_ctrl: vector table, directed corner cases
// and random stimulus against a clock-budget reference model.
module tb_delay_ctrl;

    localparam int PRESCALE = 4;
    localparam int DLY_W    = 4;
    localparam int PS_W     = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             dly_req;
    logic [DLY_W-1:0] dly_val;
    logic             halt;
    logic             pause;
    logic             delay;
    logic             count_done;
    logic             busy;
    logic [DLY_W-1:0] remain;

    int n_checks = 0;
    int n_fail   = 0;
    int pc_adv   = 0;

    // Reference model: 0 idle, 1 counting, 2 done; left = clocks still to run.
    int m_phase = 0;
    int m_left  = 0;

    typedef struct {
        logic       req;
        logic       hlt;
        logic       pse;
        logic [3:0] val;
        logic       exp_delay;
        logic       exp_done;
        logic       exp_busy;
        logic [3:0] exp_rem;
    } vec_t;

    vec_t vecs[12];

    delay_ctrl #(
        .PRESCALE (PRESCALE),
        .DLY_W    (DLY_W),
        .PS_W     (PS_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dly_req    (dly_req),
        .dly_val    (dly_val),
        .halt       (halt),
        .pause      (pause),
        .delay      (delay),
        .count_done (count_done),
        .busy       (busy),
        .remain     (remain)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!rst) begin
            m_phase = 0;
            m_left  = 0;
        end else if (m_phase == 0) begin
            if (dly_req && !halt) begin
                if (dly_val == 0) begin
                    m_phase = 2;
                end else begin
                    m_phase = 1;
                    m_left  = int'(dly_val) * PRESCALE;
                end
            end
        end else if (!dly_req || halt) begin
            m_phase = 0;
            m_left  = 0;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (!pause) begin
            m_left--;
            if (m_left == 0) m_phase = 2;
        end
    endtask

    task automatic model_compare();
        int exp_rem;
        exp_rem = (m_phase == 1) ? (m_left + PRESCALE - 1) / PRESCALE : 0;
        check("model_delay", 32'(delay), 32'(dly_req && !halt));
        check("model_count_done", 32'(count_done), 32'(m_phase == 2));
        check("model_busy", 32'(busy), 32'(m_phase != 0));
        check("model_remain", 32'(remain), 32'(exp_rem));
    endtask

    // One clock: inputs settle, edge, model update, compare on the falling edge.
    task automatic cyc();
        #1;
        if (!delay || count_done) pc_adv++;
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_compare();
    endtask

    task automatic idle_inputs();
        dly_req = 1'b0;
        dly_val = '0;
        halt    = 1'b0;
        pause   = 1'b0;
    endtask

    initial begin
        int first;
        int second;
        int pulses;
        int rem_at[17];

        rst = 1'b0;
        idle_inputs();
        cyc();
        cyc();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count_done", 32'(count_done), 32'd0);
        check("reset_remain", 32'(remain), 32'd0);
        rst = 1'b1;
        cyc();

        // Hand-computed vector table, starting from IDLE.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 4'd1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 4'd1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 4'd1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 4'd1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1, 4'd1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b1, 4'd0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0};
        for (int i = 0; i < 12; i++) begin
            dly_req = vecs[i].req;
            halt    = vecs[i].hlt;
            pause   = vecs[i].pse;
            dly_val = vecs[i].val;
            #1;
            check($sformatf("vec%0d_delay", i), 32'(delay), 32'(vecs[i].exp_delay));
            cyc();
            check($sformatf("vec%0d_count_done", i), 32'(count_done), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_remain", i), 32'(remain), 32'(vecs[i].exp_rem));
        end

        // N = 3: done after 3*4+1 edges, one PC advance.
        pc_adv  = 0;
        first   = 0;
        pulses  = 0;
        dly_req = 1'b1;
        dly_val = 4'd3;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            rem_at[k] = int'(remain);
            if (count_done) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        check("n3_done_edge", 32'(first), 32'd13);
        check("n3_pulses", 32'(pulses), 32'd1);
        check("n3_rem_e1", 32'(rem_at[1]), 32'd3);
        check("n3_rem_e5", 32'(rem_at[5]), 32'd2);
        check("n3_rem_e9", 32'(rem_at[9]), 32'd1);
        check("n3_rem_e13", 32'(rem_at[13]), 32'd0);
        check("n3_pc_advance", 32'(pc_adv), 32'd1);
        idle_inputs();
        cyc();

        // Halt at edge 5 aborts without a pulse.
        pulses  = 0;
        dly_req = 1'b1;
        dly_val = 4'd2;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (count_done) pulses++;
        end
        halt = 1'b1;
        #1;
        check("halt_delay_low", 32'(delay), 32'd0);
        cyc();
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_remain", 32'(remain), 32'd0);
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (count_done) pulses++;
        end
        check("halt_no_pulse", 32'(pulses), 32'd0);
        idle_inputs();
        cyc();

        // Pause for edges 4..6 pushes done from edge 9 to edge 12.
        first   = 0;
        dly_req = 1'b1;
        dly_val = 4'd2;
        for (int k = 1; k <= 14; k++) begin
            pause = (k >= 4 && k <= 6);
            cyc();
            if (k >= 4 && k <= 6) check($sformatf("pause_rem_e%0d", k), 32'(remain), 32'd2);
            if (count_done && first == 0) first = k;
        end
        check("pause_done_edge", 32'(first), 32'd12);
        idle_inputs();
        cyc();

        // Back-to-back DELAY 1 then 2 with dly_req held.
        first   = 0;
        second  = 0;
        dly_req = 1'b1;
        dly_val = 4'd1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (count_done) begin
                if (first == 0) begin
                    first   = k;
                    dly_val = 4'd2;
                end else if (second == 0) begin
                    second = k;
                end
            end
            if (first != 0 && k == first + 2) check("b2b_reload", 32'(remain), 32'd2);
        end
        check("b2b_first_edge", 32'(first), 32'd5);
        check("b2b_gap", 32'(second - first), 32'd10);
        idle_inputs();
        cyc();

        // Asynchronous reset mid-count with dly_req held.
        dly_req = 1'b1;
        dly_val = 4'd5;
        cyc();
        cyc();
        cyc();
        check("rst_pre_remain", 32'(remain), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_count_done", 32'(count_done), 32'd0);
        check("rst_async_remain", 32'(remain), 32'd0);
        check("rst_delay_held", 32'(delay), 32'd1);
        cyc();
        rst = 1'b1;
        cyc();
        check("rst_restart_remain", 32'(remain), 32'd5);
        check("rst_restart_busy", 32'(busy), 32'd1);
        idle_inputs();
        cyc();

        // Maximum operand, no wrap: done at 15*4+1.
        first   = 0;
        dly_req = 1'b1;
        dly_val = 4'd15;
        for (int k = 1; k <= 70; k++) begin
            cyc();
            if (k == 1) check("max_load", 32'(remain), 32'd15);
            if (count_done && first == 0) first = k;
        end
        check("max_done_edge", 32'(first), 32'd61);
        idle_inputs();
        cyc();

        // Random stimulus against the model.
        for (int k = 0; k < 600; k++) begin
            dly_req = ($urandom_range(0, 9) != 0);
            halt    = ($urandom_range(0, 29) == 0);
            pause   = ($urandom_range(0, 3) == 0);
            dly_val = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
